// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core memory-port arbiter.
//
// Contents:
//   F3_*         RV32I load/store width codes (funct3)
//   arb_state_t  arbiter FSM states
//   grant_t      identifies which requester owns (or last owned) the bus
//   NOP_INSN     instruction returned to fetch when the bus watchdog expires
package riscv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for the data port (purely combinational).
//
// Ports:
//   is_store_i    1 = store access, 0 = load access
//   funct3_i      RV32I width code of the access
//   addr_lo_i     byte offset within the 32-bit word
//   wdata_i       store data from the core (rs2)
//   rdata_i       raw word read from the bus
//   wstrb_o       byte-lane write strobes (0 for loads)
//   wdata_o       store data replicated onto every lane it may land on
//   rdata_o       selected load lane, sign/zero extended to 32 bits
//   misaligned_o  access cannot be issued: misaligned or unsupported funct3
module load_store_align
    import riscv_mem_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        misaligned_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (addr_lo_i)
            2'd0: byte_sel = rdata_i[7:0];
            2'd1: byte_sel = rdata_i[15:8];
            2'd2: byte_sel = rdata_i[23:16];
            2'd3: byte_sel = rdata_i[31:24];
            default: byte_sel = rdata_i[7:0];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        wstrb_o      = 4'b0000;
        wdata_o      = 32'd0;
        rdata_o      = 32'd0;
        misaligned_o = 1'b0;
        if (is_store_i) begin
            case (funct3_i)
                F3_B: begin
                    wstrb_o = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    misaligned_o = addr_lo_i[0];
                    wstrb_o      = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wdata_o      = {2{wdata_i[15:0]}};
                end
                F3_W: begin
                    misaligned_o = (addr_lo_i != 2'b00);
                    wstrb_o      = 4'b1111;
                    wdata_o      = wdata_i;
                end
                default: misaligned_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B:  rdata_o = {{24{byte_sel[7]}}, byte_sel};
                F3_BU: rdata_o = {24'd0, byte_sel};
                F3_H: begin
                    misaligned_o = addr_lo_i[0];
                    rdata_o      = {{16{half_sel[15]}}, half_sel};
                end
                F3_HU: begin
                    misaligned_o = addr_lo_i[0];
                    rdata_o      = {16'd0, half_sel};
                end
                F3_W: begin
                    misaligned_o = (addr_lo_i != 2'b00);
                    rdata_o      = rdata_i;
                end
                default: misaligned_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit req/ack memory bus between the core's instruction-fetch
// port and its load/store port, stalling the core until its accesses finish.
//
// Build option:
//   BUS_TIMEOUT_EN  when defined, a watchdog aborts a transfer that has held
//                   bus_req for TIMEOUT_CYCLES cycles without bus_ack.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   if_req/if_addr             fetch request (held until if_valid)
//   if_rdata/if_valid          fetched instruction and one-cycle done pulse
//   dm_read/dm_write           load/store request (held until dm_valid)
//   dm_funct3/dm_addr/dm_wdata load/store width, byte address, store data
//   dm_rdata/dm_valid/dm_err   aligned load result, done pulse, error flag
//   bus_req/bus_we/bus_addr    bus request, direction, word address
//   bus_wstrb/bus_wdata        byte strobes and lane-replicated store data
//   bus_rdata/bus_ack          bus read data and transfer-complete strobe
//   core_stall                 freeze the core while any access is open
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; arbitrate pending requests, flag bad data accesses
// FETCH | fetch transfer on the bus, waiting for bus_ack
// DATA  | load/store transfer on the bus, waiting for bus_ack
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              dm_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_wstrb,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              core_stall
);

    arb_state_t        state_q,      state_d;
    grant_t            last_grant_q, last_grant_d;
    logic              bus_req_q,    bus_req_d;
    logic              bus_we_q,     bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
    logic [3:0]        bus_wstrb_q,  bus_wstrb_d;
    logic [31:0]       bus_wdata_q,  bus_wdata_d;
    logic [31:0]       if_rdata_q,   if_rdata_d;
    logic              if_valid_q,   if_valid_d;
    logic [31:0]       dm_rdata_q,   dm_rdata_d;
    logic              dm_valid_q,   dm_valid_d;
    logic              dm_err_q,     dm_err_d;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] WD_LOAD = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wd_cnt_q, wd_cnt_d;
`else
    // The watchdog constants only matter when the timeout is built in.
    logic unused_wd_cfg;
    assign unused_wd_cfg = ^{NOP_INSN, 32'(TIMEOUT_CYCLES)};
`endif

    // Fetches are word aligned; the low address bits carry no information.
    logic unused_if_addr;
    assign unused_if_addr = ^if_addr[1:0];

    logic        al_misaligned;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    // Requesters hold their inputs until the valid pulse, so the live
    // dm_* signals are still correct on the cycle bus_ack arrives.
    load_store_align u_align (
        .is_store_i   (dm_write),
        .funct3_i     (dm_funct3),
        .addr_lo_i    (dm_addr[1:0]),
        .wdata_i      (dm_wdata),
        .rdata_i      (bus_rdata),
        .wstrb_o      (al_wstrb),
        .wdata_o      (al_wdata),
        .rdata_o      (al_rdata),
        .misaligned_o (al_misaligned)
    );

    // A request is still asserted on the cycle its valid pulse is visible;
    // masking with the pulse keeps it from being granted a second time.
    logic data_pend;
    logic fetch_pend;
    logic grant_data;

    assign data_pend  = (dm_read | dm_write) & ~dm_valid_q;
    assign fetch_pend = if_req & ~if_valid_q;
    assign grant_data = data_pend & (~fetch_pend | (last_grant_q == GRANT_FETCH));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wstrb_d  = bus_wstrb_q;
        bus_wdata_d  = bus_wdata_q;
        if_rdata_d   = if_rdata_q;
        if_valid_d   = 1'b0;
        dm_rdata_d   = dm_rdata_q;
        dm_valid_d   = 1'b0;
        dm_err_d     = 1'b0;
`ifdef BUS_TIMEOUT_EN
        wd_cnt_d     = wd_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    last_grant_d = GRANT_DATA;
                    if (al_misaligned) begin
                        dm_valid_d = 1'b1;
                        dm_err_d   = 1'b1;
                        dm_rdata_d = 32'd0;
                    end else begin
                        state_d     = ST_DATA;
                        bus_req_d   = 1'b1;
                        bus_we_d    = dm_write;
                        bus_addr_d  = {dm_addr[ADDR_W-1:2], 2'b00};
                        bus_wstrb_d = al_wstrb;
                        bus_wdata_d = al_wdata;
`ifdef BUS_TIMEOUT_EN
                        wd_cnt_d    = WD_LOAD;
`endif
                    end
                end else if (fetch_pend) begin
                    last_grant_d = GRANT_FETCH;
                    state_d      = ST_FETCH;
                    bus_req_d    = 1'b1;
                    bus_we_d     = 1'b0;
                    bus_addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
                    bus_wstrb_d  = 4'b0000;
                    bus_wdata_d  = 32'd0;
`ifdef BUS_TIMEOUT_EN
                    wd_cnt_d     = WD_LOAD;
`endif
                end
            end

            ST_FETCH: begin
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    if_valid_d  = 1'b1;
                    if_rdata_d  = bus_rdata;
                end
`ifdef BUS_TIMEOUT_EN
                else if (wd_cnt_q == 8'd0) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    if_valid_d  = 1'b1;
                    if_rdata_d  = NOP_INSN;
                end else begin
                    wd_cnt_d = wd_cnt_q - 8'd1;
                end
`endif
            end

            ST_DATA: begin
                if (bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    dm_valid_d  = 1'b1;
                    dm_rdata_d  = dm_write ? 32'd0 : al_rdata;
                end
`ifdef BUS_TIMEOUT_EN
                else if (wd_cnt_q == 8'd0) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_wstrb_d = 4'b0000;
                    dm_valid_d  = 1'b1;
                    dm_err_d    = 1'b1;
                    dm_rdata_d  = 32'd0;
                end else begin
                    wd_cnt_d = wd_cnt_q - 8'd1;
                end
`endif
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_FETCH;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wstrb_q  <= 4'b0000;
            bus_wdata_q  <= 32'd0;
            if_rdata_q   <= 32'd0;
            if_valid_q   <= 1'b0;
            dm_rdata_q   <= 32'd0;
            dm_valid_q   <= 1'b0;
            dm_err_q     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
            wd_cnt_q     <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wstrb_q  <= bus_wstrb_d;
            bus_wdata_q  <= bus_wdata_d;
            if_rdata_q   <= if_rdata_d;
            if_valid_q   <= if_valid_d;
            dm_rdata_q   <= dm_rdata_d;
            dm_valid_q   <= dm_valid_d;
            dm_err_q     <= dm_err_d;
`ifdef BUS_TIMEOUT_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    // A simultaneous load and store is a core bug; the store is served.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(dm_read && dm_write));
        end
    end

    assign if_rdata   = if_rdata_q;
    assign if_valid   = if_valid_q;
    assign dm_rdata   = dm_rdata_q;
    assign dm_valid   = dm_valid_q;
    assign dm_err     = dm_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wstrb  = bus_wstrb_q;
    assign bus_wdata  = bus_wdata_q;
    assign core_stall = (if_req & ~if_valid_q) | ((dm_read | dm_write) & ~dm_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import riscv_mem_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_rdata;
    logic              if_valid;
    logic              dm_read;
    logic              dm_write;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_valid;
    logic              dm_err;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_wdata;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic              core_stall;

    int checks   = 0;
    int failures = 0;

    logic bus_auto  = 1'b1;
    int   bus_waits = 0;
    int   wcnt      = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .dm_read(dm_read), .dm_write(dm_write), .dm_funct3(dm_funct3),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_valid(dm_valid), .dm_err(dm_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .core_stall(core_stall)
    );

    always #5 clk = ~clk;

    // Bus slave: acks after bus_waits cycles of bus_req
    always begin
        @(posedge clk);
        #2;
        if (bus_auto) begin
            if (!bus_req) begin
                bus_ack = 1'b0;
                wcnt    = 0;
            end else if (wcnt >= bus_waits) begin
                bus_ack = 1'b1;
            end else begin
                bus_ack = 1'b0;
                wcnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_read = 1'b0; dm_write = 1'b0;
        dm_funct3 = F3_W; dm_addr = '0; dm_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({bus_req, bus_we, bus_wstrb, if_valid, dm_valid, dm_err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_ctrl actual=%b required=000000000",
                     {bus_req, bus_we, bus_wstrb, if_valid, dm_valid, dm_err});
        end
        checks++;
        if ({bus_addr, bus_wdata, if_rdata, dm_rdata} !== 128'd0) begin
            failures++;
            $display("FAIL reset_data actual=%h/%h/%h/%h required=0",
                     bus_addr, bus_wdata, if_rdata, dm_rdata);
        end
        checks++;
        if (core_stall !== 1'b0) begin
            failures++; $display("FAIL reset_stall actual=%b required=0", core_stall);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        bus_waits = 0; bus_rdata = 32'h0000_0013;
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        checks++;
        if (core_stall !== 1'b1) begin
            failures++; $display("FAIL fetch_stall0 actual=%b required=1", core_stall);
        end
        tick();
        checks++;
        if ({bus_req, bus_we, if_valid, core_stall} !== 4'b1001 || bus_addr !== 32'h100) begin
            failures++;
            $display("FAIL fetch_issue req/we/valid/stall=%b addr=%h required=1001 addr=00000100",
                     {bus_req, bus_we, if_valid, core_stall}, bus_addr);
        end
        tick();
        checks++;
        if ({if_valid, bus_req, core_stall} !== 3'b100 || if_rdata !== 32'h13) begin
            failures++;
            $display("FAIL fetch_done valid/req/stall=%b rdata=%h required=100 rdata=00000013",
                     {if_valid, bus_req, core_stall}, if_rdata);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_valid !== 1'b0) begin
            failures++; $display("FAIL fetch_pulse actual=%b required=0", if_valid);
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] grants [4];
        logic [31:0] exp_g  [4];
        int   n = 0;
        logic prev = 1'b0;
        exp_g[0] = 32'h40; exp_g[1] = 32'h80; exp_g[2] = 32'h40; exp_g[3] = 32'h80;
        do_reset();
        bus_waits = 1; bus_rdata = 32'h1234_5678;
        if_addr = 32'h80; dm_addr = 32'h40; dm_funct3 = F3_W;
        if_req = 1'b1; dm_read = 1'b1;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick();
            if (bus_req && !prev) begin
                grants[n] = bus_addr;
                n++;
            end
            prev = bus_req;
        end
        checks++;
        if (n !== 4) begin
            failures++; $display("FAIL arb_grant_count actual=%0d required=4", n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (grants[i] !== exp_g[i]) begin
                failures++;
                $display("FAIL arb_order[%0d] actual=%h required=%h", i, grants[i], exp_g[i]);
            end
        end
        if_req = 1'b0; dm_read = 1'b0;
        for (int i = 0; i < 6; i++) tick();
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } st_vec_t;

    localparam st_vec_t ST_VEC [4] = '{
        '{F3_B, 32'h203, 4'b1000, 32'hEFEF_EFEF},
        '{F3_H, 32'h202, 4'b1100, 32'hBEEF_BEEF},
        '{F3_W, 32'h204, 4'b1111, 32'hDEAD_BEEF},
        '{F3_B, 32'h201, 4'b0010, 32'hEFEF_EFEF}
    };

    task automatic test_stores();
        do_reset();
        bus_waits = 2;
        for (int v = 0; v < 4; v++) begin
            dm_funct3 = ST_VEC[v].f3; dm_addr = ST_VEC[v].addr;
            dm_wdata = 32'hDEAD_BEEF; dm_write = 1'b1;
            tick();
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== {ST_VEC[v].addr[31:2], 2'b00}
                || bus_wstrb !== ST_VEC[v].strb || bus_wdata !== ST_VEC[v].wdata) begin
                failures++;
                $display("FAIL store[%0d] req=%b we=%b addr=%h strb=%b wdata=%h required strb=%b wdata=%h",
                         v, bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
                         ST_VEC[v].strb, ST_VEC[v].wdata);
            end
            for (int i = 0; i < 20 && !dm_valid; i++) tick();
            checks++;
            if (dm_valid !== 1'b1 || dm_err !== 1'b0) begin
                failures++;
                $display("FAIL store_done[%0d] valid=%b err=%b required valid=1 err=0",
                         v, dm_valid, dm_err);
            end
            dm_write = 1'b0;
            tick();
        end
    endtask

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
    } ld_vec_t;

    localparam ld_vec_t LD_VEC [7] = '{
        '{F3_B,  32'h0, 32'hFFFF_FFEF},
        '{F3_BU, 32'h0, 32'h0000_00EF},
        '{F3_H,  32'h2, 32'hFFFF_DEAD},
        '{F3_HU, 32'h2, 32'h0000_DEAD},
        '{F3_W,  32'h0, 32'hDEAD_BEEF},
        '{F3_B,  32'h3, 32'hFFFF_FFDE},
        '{F3_BU, 32'h1, 32'h0000_00BE}
    };

    task automatic test_loads();
        int lat;
        do_reset();
        bus_waits = 0; bus_rdata = 32'hDEAD_BEEF;
        for (int v = 0; v < 7; v++) begin
            dm_funct3 = LD_VEC[v].f3; dm_addr = LD_VEC[v].addr; dm_read = 1'b1;
            tick();
            lat = 1;
            checks++;
            if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_wstrb !== 4'b0000) begin
                failures++;
                $display("FAIL load_issue[%0d] req=%b we=%b strb=%b required 1/0/0000",
                         v, bus_req, bus_we, bus_wstrb);
            end
            for (int i = 0; i < 20 && !dm_valid; i++) begin
                tick();
                lat++;
            end
            checks++;
            if (dm_valid !== 1'b1 || lat !== 2 || dm_rdata !== LD_VEC[v].exp || dm_err !== 1'b0) begin
                failures++;
                $display("FAIL load[%0d] valid=%b latency=%0d rdata=%h err=%b required latency=2 rdata=%h err=0",
                         v, dm_valid, lat, dm_rdata, dm_err, LD_VEC[v].exp);
            end
            dm_read = 1'b0;
            tick();
        end
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3v [3];
        logic [31:0] adv [3];
        logic        wrv [3];
        f3v[0] = F3_W;   adv[0] = 32'h102; wrv[0] = 1'b0;
        f3v[1] = F3_H;   adv[1] = 32'h201; wrv[1] = 1'b1;
        f3v[2] = 3'b011; adv[2] = 32'h000; wrv[2] = 1'b0;
        do_reset();
        dm_funct3 = F3_BU; dm_addr = 32'h1; bus_rdata = 32'hDEAD_BEEF; dm_read = 1'b1;
        for (int i = 0; i < 20 && !dm_valid; i++) tick();
        dm_read = 1'b0;
        tick();
        for (int v = 0; v < 3; v++) begin
            dm_funct3 = f3v[v]; dm_addr = adv[v]; dm_wdata = 32'h5555_AAAA;
            dm_read = ~wrv[v]; dm_write = wrv[v];
            tick();
            checks++;
            if ({dm_valid, dm_err, bus_req} !== 3'b110 || dm_rdata !== 32'd0) begin
                failures++;
                $display("FAIL misaligned[%0d] valid/err/req=%b rdata=%h required 110 rdata=0",
                         v, {dm_valid, dm_err, bus_req}, dm_rdata);
            end
            dm_read = 1'b0; dm_write = 1'b0;
            tick();
            checks++;
            if ({dm_valid, dm_err, bus_req} !== 3'b000) begin
                failures++;
                $display("FAIL misaligned_after[%0d] valid/err/req=%b required 000",
                         v, {dm_valid, dm_err, bus_req});
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus_auto = 1'b0; bus_ack = 1'b0; bus_rdata = 32'hCAFE_F00D;
        dm_funct3 = F3_W; dm_addr = 32'h300; dm_read = 1'b1;
        tick();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++; $display("FAIL rst_mid_issue actual=%b required=1", bus_req);
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        checks++;
        if (bus_req !== 1'b0 || dut.state_q !== ST_IDLE || dm_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_state req=%b state=%0d valid=%b required req=0 state=0 valid=0",
                     bus_req, dut.state_q, dm_valid);
        end
        reset = 1'b0; dm_read = 1'b0; bus_ack = 1'b1;
        tick();
        checks++;
        if ({dm_valid, if_valid, bus_req} !== 3'b000) begin
            failures++;
            $display("FAIL rst_late_ack valid/ifvalid/req=%b required 000",
                     {dm_valid, if_valid, bus_req});
        end
        bus_ack = 1'b0;
        tick();
        checks++;
        if (dm_valid !== 1'b0) begin
            failures++; $display("FAIL rst_late_ack2 actual=%b required=0", dm_valid);
        end
        bus_auto = 1'b1;
    endtask

`ifdef BUS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        bus_auto = 1'b0; bus_ack = 1'b0;
        dm_funct3 = F3_W; dm_addr = 32'h40; dm_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus_req !== 1'b1 || dm_valid !== 1'b0) begin
                failures++;
                $display("FAIL timeout_wait[%0d] req=%b valid=%b required 1/0", i, bus_req, dm_valid);
            end
        end
        tick();
        checks++;
        if ({dm_valid, dm_err, bus_req} !== 3'b110 || dm_rdata !== 32'd0) begin
            failures++;
            $display("FAIL timeout_done valid/err/req=%b rdata=%h required 110 rdata=0",
                     {dm_valid, dm_err, bus_req}, dm_rdata);
        end
        dm_read = 1'b0;
        tick();
        bus_auto = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_time_limit reached without finishing");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_stores();
        test_loads();
        test_misaligned();
        test_reset_mid();
`ifdef BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
